ama_pipe_adder: RTL and testbench

Parametrised, pipelined successor to the fixed 24-bit approximate-mirror adder. The datapath is split into 4-bit nibble cells. The number of low nibbles that use the approximate cell is selected per transaction at run time. The carry chain is registered every `NPS` nibbles, and valid/ready handshakes sit on both sides. A shadow exact adder feeds a saturating mismatch counter, so benches and accuracy-characterisation flows can measure the error rate in-line.

---
 rtl/ama_pipe_adder.sv | 171 +++++++++++++++++
 tb/tb_ama_pipe_adder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ama_pipe_adder.sv
// ama_pipe_adder
//   Pipelined approximate-mirror adder built from 4-bit nibble cells.
//   The low `appr_cnt` nibbles of each transaction use the approximate cell
//   (s = a|b, carry-out = a[3]&b[3], carry-in ignored). The others are exact.
//   The carry chain is cut by a register every NPS nibbles, which gives
//   STAGES = NB/NPS pipeline stages. A shadow exact sum is computed at the
//   output. A saturating counter tracks how many delivered results differed
//   from that exact sum.
//
// Ports
//   clk, rst             : clock and synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   a, b, cin, appr_cnt  : operands, carry-in, count of approximate low nibbles
//   out_valid / out_ready: output handshake
//   sum, cout            : result held in the last stage register
//   err_cnt, clr_err     : mismatch counter and its synchronous clear
module ama_pipe_adder #(
  parameter int WIDTH = 24,
  parameter int NPS   = 2,
  parameter int ECW   = 16,
  localparam int NB   = WIDTH / 4,
  localparam int ACW  = $clog2(NB + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [ACW-1:0]   appr_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [ECW-1:0]   err_cnt,
  input  logic             clr_err
);

  localparam int STAGES = NB / NPS;
  localparam logic [ACW-1:0] NB_AC = ACW'(NB);

  // Computes nibbles first .. first+NPS-1 on top of the partial sum `part`.
  // Returns {carry_out, updated_partial_sum}.
  function automatic logic [WIDTH:0] stage_calc(
    input int               first,
    input logic [WIDTH-1:0] op_a,
    input logic [WIDTH-1:0] op_b,
    input logic [WIDTH-1:0] part,
    input logic             c_in,
    input logic [ACW-1:0]   ac
  );
    logic [WIDTH-1:0] s;
    logic             c;
    logic [4:0]       t;
    logic [3:0]       na;
    logic [3:0]       nb;
    s = part;
    c = c_in;
    for (int j = 0; j < NPS; j++) begin
      na = op_a[4*(first+j) +: 4];
      nb = op_b[4*(first+j) +: 4];
      t  = {1'b0, na} + {1'b0, nb} + {4'b0000, c};
      if ((first + j) < int'(ac)) begin
        // Approximate cell drops the incoming carry but still produces one.
        s[4*(first+j) +: 4] = na | nb;
        c = na[3] & nb[3];
      end else begin
        s[4*(first+j) +: 4] = t[3:0];
        c = t[4];
      end
    end
    return {c, s};
  endfunction

  // Global stall: every stage holds while the output is blocked.
  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Stage registers (index k holds the result of stage k+1).
  logic             v_reg   [STAGES];
  logic [WIDTH-1:0] s_reg   [STAGES];
  logic             c_reg   [STAGES];
  logic [WIDTH-1:0] a_reg   [STAGES];
  logic [WIDTH-1:0] b_reg   [STAGES];
  logic             cin_reg [STAGES];
  logic [ACW-1:0]   ac_reg  [STAGES];

  // Stage inputs and combinational stage results.
  logic             st_v   [STAGES];
  logic [WIDTH-1:0] st_a   [STAGES];
  logic [WIDTH-1:0] st_b   [STAGES];
  logic [WIDTH-1:0] st_s   [STAGES];
  logic             st_c   [STAGES];
  logic             st_cin [STAGES];
  logic [ACW-1:0]   st_ac  [STAGES];
  logic [WIDTH:0]   calc   [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign st_v[gi]   = in_valid;
        assign st_a[gi]   = a;
        assign st_b[gi]   = b;
        assign st_s[gi]   = '0;
        assign st_c[gi]   = cin;
        assign st_cin[gi] = cin;
        // Out-of-range counts behave as "all nibbles approximate".
        assign st_ac[gi]  = (appr_cnt > NB_AC) ? NB_AC : appr_cnt;
      end else begin : g_body
        assign st_v[gi]   = v_reg[gi-1];
        assign st_a[gi]   = a_reg[gi-1];
        assign st_b[gi]   = b_reg[gi-1];
        assign st_s[gi]   = s_reg[gi-1];
        assign st_c[gi]   = c_reg[gi-1];
        assign st_cin[gi] = cin_reg[gi-1];
        assign st_ac[gi]  = ac_reg[gi-1];
      end
      assign calc[gi] = stage_calc(gi * NPS, st_a[gi], st_b[gi], st_s[gi],
                                   st_c[gi], st_ac[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]   <= 1'b0;
        s_reg[k]   <= '0;
        c_reg[k]   <= 1'b0;
        a_reg[k]   <= '0;
        b_reg[k]   <= '0;
        cin_reg[k] <= 1'b0;
        ac_reg[k]  <= '0;
      end
    end else if (!stall) begin
      for (int k = 0; k < STAGES; k++) begin
        v_reg[k]   <= st_v[k];
        s_reg[k]   <= calc[k][WIDTH-1:0];
        c_reg[k]   <= calc[k][WIDTH];
        a_reg[k]   <= st_a[k];
        b_reg[k]   <= st_b[k];
        cin_reg[k] <= st_cin[k];
        ac_reg[k]  <= st_ac[k];
      end
    end
  end

  assign out_valid = v_reg[STAGES-1];
  assign sum       = s_reg[STAGES-1];
  assign cout      = c_reg[STAGES-1];

  // Shadow exact sum from the operands that travelled with the result.
  logic [WIDTH:0] exact_x;
  logic           mismatch;
  assign exact_x  = {1'b0, a_reg[STAGES-1]} + {1'b0, b_reg[STAGES-1]}
                  + (WIDTH+1)'(cin_reg[STAGES-1]);
  assign mismatch = ({cout, sum} != exact_x);

  logic [ECW-1:0] err_reg;
  always_ff @(posedge clk) begin
    if (rst || clr_err) begin
      err_reg <= '0;
    end else if (out_valid && out_ready && mismatch && (err_reg != '1)) begin
      err_reg <= err_reg + ECW'(1);
    end
  end
  assign err_cnt = err_reg;

endmodule

// File: tb/tb_ama_pipe_adder.sv
// tb_ama_pipe_adder
//   Directed vectors with hand-computed results. The driver pushes
//   {mismatch_flag, cout, sum} into a scoreboard queue on acceptance; a
//   monitor pops on every output handshake and checks the result and both
//   error counters (default ECW=16 instance and an ECW=4 instance).
module tb_ama_pipe_adder;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          cin = 1'b0;
  logic          out_ready = 1'b1;
  logic          clr_err = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [2:0]    appr_cnt = '0;

  logic          in_ready, out_valid, cout;
  logic [W-1:0]  sum;
  logic [15:0]   err_cnt;
  logic          s_in_ready, s_out_valid, s_cout;
  logic [W-1:0]  s_sum;
  logic [3:0]    s_err;

  always #5 clk = ~clk;

  ama_pipe_adder #(.WIDTH(W), .NPS(2), .ECW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .appr_cnt(appr_cnt),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout),
    .err_cnt(err_cnt), .clr_err(clr_err)
  );

  ama_pipe_adder #(.WIDTH(W), .NPS(2), .ECW(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .a(a), .b(b), .cin(cin), .appr_cnt(appr_cnt),
    .out_valid(s_out_valid), .out_ready(out_ready), .sum(s_sum), .cout(s_cout),
    .err_cnt(s_err), .clr_err(clr_err)
  );

  int          n_vec = 0;
  int          n_fail = 0;
  logic [25:0] exp_q[$];
  int          model_err = 0;
  int          model_sat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, req);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    logic        held_v;
    logic [24:0] held_res;
    logic [25:0] e;
    logic        hs;
    logic        mis;
    held_v = 1'b0;
    held_res = '0;
    forever begin
      @(negedge clk);
      if (held_v) chk("held_stable", {7'd0, cout, sum}, {7'd0, held_res});
      held_v   = out_valid && !out_ready && !rst;
      held_res = {cout, sum};
      hs  = !rst && out_valid && out_ready;
      mis = 1'b0;
      if (hs) begin
        chk("err_cnt", {16'd0, err_cnt}, model_err);
        chk("err_cnt_ecw4", {28'd0, s_err}, model_sat);
        if (exp_q.size() == 0) begin
          n_vec++;
          n_fail++;
          $display("FAIL unexpected_output: got %h, want no output", {cout, sum});
        end else begin
          e = exp_q.pop_front();
          $display("result %h (expected %h)", {cout, sum}, e[24:0]);
          chk("result", {7'd0, cout, sum}, {7'd0, e[24:0]});
          mis = e[25];
        end
      end
      if (rst || clr_err) begin
        model_err = 0;
        model_sat = 0;
      end else if (hs && mis) begin
        if (model_err < 65535) model_err++;
        if (model_sat < 15) model_sat++;
      end
    end
  end

  task automatic send(input logic [23:0] va, input logic [23:0] vb, input logic vc,
                      input logic [2:0] vac, input logic [24:0] res, input logic mis);
    int n;
    n = 0;
    in_valid = 1'b1;
    a = va;
    b = vb;
    cin = vc;
    appr_cnt = vac;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready %b, want 1", in_ready);
    end else begin
      exp_q.push_back({mis, res});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_fail++;
      $display("FAIL drain: %0d results outstanding, want 0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_sum", {8'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_err_cnt", {16'd0, err_cnt}, 0);
    @(posedge clk);
    #1;

    // Exact path and its three-edge latency.
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd0, 25'h0A0C7EB, 1'b0);
    @(negedge clk); chk("lat_edge1_valid", {31'd0, out_valid}, 0);
    @(negedge clk); chk("lat_edge2_valid", {31'd0, out_valid}, 0);
    @(negedge clk); chk("lat_edge3_valid", {31'd0, out_valid}, 1);
    drain();
    chk("err_after_exact", {16'd0, err_cnt}, 0);

    // One approximate nibble.
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd1, 25'h0A0C7ED, 1'b1);
    drain();
    chk("err_after_one_approx", {16'd0, err_cnt}, 1);

    // Back-to-back mix: all-approx, exact overflow, clamp 7->6, partial,
    // approximate top carry, approximate but numerically exact.
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd6, 25'h09F7FBD, 1'b1);
    send(24'hFFFFFF, 24'h000001, 1'b0, 3'd0, 25'h1000000, 1'b0);
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd7, 25'h09F7FBD, 1'b1);
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd3, 25'h0A0CFBD, 1'b1);
    send(24'h800000, 24'h800000, 1'b0, 3'd6, 25'h1800000, 1'b1);
    send(24'h00000F, 24'h00000F, 1'b1, 3'd1, 25'h000001F, 1'b0);
    drain();
    chk("err_after_mix", {16'd0, err_cnt}, 5);

    // Backpressure: out_ready low for four edges while streaming five.
    fork
      begin
        send(24'h000001, 24'h000002, 1'b0, 3'd0, 25'h0000003, 1'b0);
        send(24'h111111, 24'h222222, 1'b0, 3'd0, 25'h0333333, 1'b0);
        send(24'h800000, 24'h800000, 1'b0, 3'd0, 25'h1000000, 1'b0);
        send(24'h0F0F0F, 24'h010101, 1'b1, 3'd0, 25'h0101011, 1'b0);
        send(24'h123456, 24'h654321, 1'b0, 3'd0, 25'h0777777, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_in_ready", {31'd0, in_ready}, 0);
        chk("stall_out_valid", {31'd0, out_valid}, 1);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();
    chk("err_after_stream", {16'd0, err_cnt}, 5);

    // Reset with two transactions in flight.
    send(24'h000005, 24'h000006, 1'b0, 3'd0, 25'h000000B, 1'b0);
    send(24'hABCDEF, 24'h111111, 1'b0, 3'd0, 25'h0BCDF00, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_out_valid", {31'd0, out_valid}, 0);
    chk("midrst_err_cnt", {16'd0, err_cnt}, 0);
    chk("midrst_in_ready", {31'd0, in_ready}, 1);
    repeat (8) @(posedge clk);
    #1;

    // Saturation of the 4-bit counter.
    for (int i = 0; i < 20; i++)
      send(24'h135FAD, 24'h8D683D, 1'b1, 3'd1, 25'h0A0C7ED, 1'b1);
    drain();
    chk("sat_err_ecw4", {28'd0, s_err}, 15);
    chk("sat_err_ecw16", {16'd0, err_cnt}, 20);

    // Clear beats a simultaneous mismatching handshake.
    send(24'h135FAD, 24'h8D683D, 1'b1, 3'd1, 25'h0A0C7ED, 1'b1);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      chk("clr_wait_valid", {31'd0, out_valid}, 1);
    end
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    chk("clr_err_ecw16", {16'd0, err_cnt}, 0);
    chk("clr_err_ecw4", {28'd0, s_err}, 0);

    drain();
    chk("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
